// File: rtl/ulpb_pkg.sv
// ulpb_pkg: shared ULPB widths, broadcast address, state encodings and address matching
package ulpb_pkg;
  localparam int ULPB_ADDR_WIDTH = 8;
  localparam int ULPB_DATA_WIDTH = 32;
  localparam logic [ULPB_ADDR_WIDTH-1:0] ULPB_BCAST_ADDR = '1;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } ulpb_state_e;
  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] mine, input logic [31:0] bcast);
    return (addr == mine) || (addr == bcast);
  endfunction
endpackage

// File: rtl/ulpb_rx_if.sv
// ulpb_rx_if: serial bus strobes into the receiver and the receive-buffer/status side out of it
interface ulpb_rx_if
  import ulpb_pkg::*;
#(
  parameter int ADDR_WIDTH = ULPB_ADDR_WIDTH,
  parameter int DATA_WIDTH = ULPB_DATA_WIDTH
);
  logic                  IN;
  logic                  IN_VALID;
  logic                  FRAME_START;
  logic                  FRAME_END;
  logic [DATA_WIDTH-1:0] RX_DATA;
  logic                  RX_VALID;
  logic                  RX_ACK;
  logic [ADDR_WIDTH-1:0] RX_ADDR;
  logic                  RX_DONE;
  logic                  RX_OK;
  modport master (
    output IN, IN_VALID, FRAME_START, FRAME_END, RX_ACK,
    input  RX_DATA, RX_VALID, RX_ADDR, RX_DONE, RX_OK
  );
  modport slave (
    input  IN, IN_VALID, FRAME_START, FRAME_END, RX_ACK,
    output RX_DATA, RX_VALID, RX_ADDR, RX_DONE, RX_OK
  );
endinterface

// File: rtl/ulpb_rx_fifo.sv
// ulpb_rx_fifo: two-entry receive FIFO; a push into a full FIFO only lands if a pop frees a slot that cycle
module ulpb_rx_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr;
  logic             r_rd;
  logic [1:0]       r_cnt;
  logic             w_pop;
  logic             w_push;
  assign o_empty = r_cnt == 2'd0;
  assign o_full  = r_cnt == 2'd2;
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = r_mem[r_rd];
  // storage and pointers; occupancy tracks accepted pushes minus pops
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) r_mem[r_wr] <= i_data;
      r_wr  <= r_wr ^ w_push;
      r_rd  <= r_rd ^ w_pop;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  end
endmodule

// File: rtl/ulpb_rx.sv
// ulpb_rx: ULPB node receiver; deserialises address and data words, buffers words, reports frame status
module ulpb_rx
  import ulpb_pkg::*;
#(
  parameter int ADDR_WIDTH = ULPB_ADDR_WIDTH,
  parameter int DATA_WIDTH = ULPB_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BCAST_ADDR = {ADDR_WIDTH{ULPB_BCAST_ADDR[0]}}
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] MY_ADDR,
  ulpb_rx_if.slave              bus
);
  localparam int CW = $clog2(DATA_WIDTH > ADDR_WIDTH ? DATA_WIDTH : ADDR_WIDTH);
  localparam logic [CW-1:0] A_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);
  ulpb_state_e           r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [ADDR_WIDTH-2:0] r_asr, w_asr_nxt;
  logic [DATA_WIDTH-1:0] r_word, w_word_nxt;
  logic [ADDR_WIDTH-1:0] r_rx_addr, w_rx_addr_nxt;
  logic                  r_push, w_push_nxt;
  logic                  r_got, w_got_nxt;
  logic                  r_ovf, w_ovf_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_ok, w_ok_nxt;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_hit;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_lost;
  assign w_addr = {r_asr, bus.IN};
  assign w_hit  = addr_hit(32'(w_addr), 32'(MY_ADDR), 32'(BCAST_ADDR));
  assign w_pop  = bus.RX_ACK & ~w_empty;
  assign w_lost = r_push & w_full & ~w_pop;
  // next state: the incoming bit is shifted first, then FRAME_END is judged on the updated counters/flags
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_asr_nxt     = r_asr;
    w_word_nxt    = r_word;
    w_rx_addr_nxt = r_rx_addr;
    w_push_nxt    = 1'b0;
    w_got_nxt     = r_got;
    w_ovf_nxt     = r_ovf | w_lost;
    w_done_nxt    = 1'b0;
    w_ok_nxt      = 1'b0;
    if (bus.FRAME_START) begin
      w_state_nxt = ST_ADDR;
      w_cnt_nxt   = A_LAST;
      w_asr_nxt   = '0;
      w_word_nxt  = '0;
      w_got_nxt   = 1'b0;
      w_ovf_nxt   = 1'b0;
    end else begin
      if (r_state == ST_ADDR && bus.IN_VALID) begin
        w_asr_nxt = w_addr[ADDR_WIDTH-2:0];
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == '0) begin
          w_rx_addr_nxt = w_addr;
          w_state_nxt   = w_hit ? ST_DATA : ST_DROP;
          w_cnt_nxt     = w_hit ? D_LAST : '0;
        end
      end
      if (r_state == ST_DATA && bus.IN_VALID) begin
        w_word_nxt = {r_word[DATA_WIDTH-2:0], bus.IN};
        w_push_nxt = r_cnt == '0;
        w_got_nxt  = r_got | (r_cnt == '0);
        w_cnt_nxt  = (r_cnt == '0) ? D_LAST : r_cnt - CW'(1);
      end
      if (r_state != ST_IDLE && bus.FRAME_END) begin
        w_done_nxt  = w_state_nxt != ST_DROP;
        w_ok_nxt    = (w_state_nxt == ST_DATA) & ~w_ovf_nxt & (w_cnt_nxt == D_LAST) & w_got_nxt;
        w_state_nxt = ST_IDLE;
      end
    end
  end
  // state and datapath registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_asr     <= '0;
      r_word    <= '0;
      r_rx_addr <= '0;
      r_push    <= 1'b0;
      r_got     <= 1'b0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
      r_ok      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_asr     <= w_asr_nxt;
      r_word    <= w_word_nxt;
      r_rx_addr <= w_rx_addr_nxt;
      r_push    <= w_push_nxt;
      r_got     <= w_got_nxt;
      r_ovf     <= w_ovf_nxt;
      r_done    <= w_done_nxt;
      r_ok      <= w_ok_nxt;
    end
  end
  ulpb_rx_fifo #(.WIDTH(DATA_WIDTH)) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_push  (r_push),
    .i_data  (r_word),
    .i_pop   (w_pop),
    .o_data  (bus.RX_DATA),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  assign bus.RX_VALID = ~w_empty;
  assign bus.RX_ADDR  = r_rx_addr;
  assign bus.RX_DONE  = r_done;
  // a last word that completes together with FRAME_END is pushed while RX_DONE is up, so its loss is folded in here
  assign bus.RX_OK    = r_ok & ~w_lost;
endmodule

// File: tb/tb_ulpb_rx.sv
// tb_ulpb_rx: table-driven frame vectors plus hand-written multi-cycle sequences for ulpb_rx
module tb_ulpb_rx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] my_addr = 8'h5A;
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         valid_cnt = 0;
  logic       last_ok = 1'b0;
  logic [31:0] q[$];

  ulpb_rx_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();
  ulpb_rx #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .CLK     (clk),
    .RESET   (rst_n),
    .MY_ADDR (my_addr),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.RX_DONE) begin
      done_cnt++;
      last_ok = bus.RX_OK;
    end
    if (bus.RX_VALID) valid_cnt++;
    if (bus.RX_VALID && bus.RX_ACK) q.push_back(bus.RX_DATA);
  end

  typedef struct {
    string       name;
    logic [7:0]  my;
    logic [7:0]  addr;
    int          abits;
    int          nbits;
    logic [95:0] data;
    int          exp_done;
    logic        exp_ok;
    int          exp_n;
    logic [7:0]  exp_rxaddr;
  } vec_t;

  vec_t tv[11];

  function automatic vec_t mk(input string n, input logic [7:0] my, input logic [7:0] a, input int ab,
                              input int nb, input logic [95:0] d, input int ed, input logic eo,
                              input int en, input logic [7:0] ra);
    vec_t v;
    v.name = n; v.my = my; v.addr = a; v.abits = ab; v.nbits = nb; v.data = d;
    v.exp_done = ed; v.exp_ok = eo; v.exp_n = en; v.exp_rxaddr = ra;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_bit(input logic b);
    bus.IN = b;
    bus.IN_VALID = 1'b1;
    tick();
    bus.IN_VALID = 1'b0;
    bus.IN = 1'b0;
  endtask

  task automatic send_addr(input logic [7:0] a);
    for (int i = 7; i >= 0; i--) send_bit(a[i]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic pulse_start();
    bus.FRAME_START = 1'b1;
    tick();
    bus.FRAME_START = 1'b0;
  endtask

  task automatic pulse_end();
    bus.FRAME_END = 1'b1;
    tick();
    bus.FRAME_END = 1'b0;
  endtask

  task automatic drain();
    bus.RX_ACK = 1'b1;
    idle(4);
    bus.RX_ACK = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int d0, v0, p0;
    logic [31:0] w;
    bus.IN = 1'b0; bus.IN_VALID = 1'b0; bus.FRAME_START = 1'b0; bus.FRAME_END = 1'b0; bus.RX_ACK = 1'b0;
    tv[0]  = mk("match",        8'h5A, 8'h5A, 8, 32, {32'hDEADBEEF, 64'h0},                   1, 1'b1, 1, 8'h5A);
    tv[1]  = mk("nomatch",      8'h5A, 8'h33, 8, 32, {32'h12345678, 64'h0},                   0, 1'b0, 0, 8'h33);
    tv[2]  = mk("bcast",        8'h5A, 8'hFF, 8, 32, {32'hCAFEF00D, 64'h0},                   1, 1'b1, 1, 8'hFF);
    tv[3]  = mk("overflow3",    8'h5A, 8'h5A, 8, 96, {32'h1, 32'h2, 32'h3},                   1, 1'b0, 2, 8'h5A);
    tv[4]  = mk("two_words",    8'h5A, 8'h5A, 8, 64, {32'h89ABCDEF, 32'h01234567, 32'h0},     1, 1'b1, 2, 8'h5A);
    tv[5]  = mk("partial16",    8'h5A, 8'h5A, 8, 16, {32'hABCD1234, 64'h0},                   1, 1'b0, 0, 8'h5A);
    tv[6]  = mk("word_partial", 8'h5A, 8'h5A, 8, 48, {32'h600DF00D, 32'h12340000, 32'h0},     1, 1'b0, 1, 8'h5A);
    tv[7]  = mk("end_in_addr",  8'h5A, 8'h5A, 4, 0,  96'h0,                                   1, 1'b0, 0, 8'h00);
    tv[8]  = mk("no_words",     8'h5A, 8'h5A, 8, 0,  96'h0,                                   1, 1'b0, 0, 8'h5A);
    tv[9]  = mk("other_node",   8'h3C, 8'h3C, 8, 32, {32'h0F0F1234, 64'h0},                   1, 1'b1, 1, 8'h3C);
    tv[10] = mk("foreign_5a",   8'h3C, 8'h5A, 8, 32, {32'h77777777, 64'h0},                   0, 1'b0, 0, 8'h5A);

    #2;
    chk("reset RX_VALID", 32'(bus.RX_VALID), 32'd0);
    chk("reset RX_DATA", bus.RX_DATA, 32'd0);
    chk("reset RX_ADDR", 32'(bus.RX_ADDR), 32'd0);
    chk("reset RX_DONE", 32'(bus.RX_DONE), 32'd0);
    chk("reset RX_OK", 32'(bus.RX_OK), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 11; k++) begin
      do_reset();
      my_addr = tv[k].my;
      d0 = done_cnt; v0 = valid_cnt; p0 = q.size();
      pulse_start();
      for (int i = 0; i < tv[k].abits; i++) send_bit(tv[k].addr[7-i]);
      for (int i = 0; i < tv[k].nbits; i++) send_bit(tv[k].data[95-i]);
      idle(2);
      pulse_end();
      idle(2);
      chk({tv[k].name, " done"}, 32'(done_cnt - d0), 32'(tv[k].exp_done));
      if (tv[k].exp_done != 0) chk({tv[k].name, " ok"}, 32'(last_ok), 32'(tv[k].exp_ok));
      chk({tv[k].name, " rx_addr"}, 32'(bus.RX_ADDR), 32'(tv[k].exp_rxaddr));
      drain();
      chk({tv[k].name, " count"}, 32'(q.size() - p0), 32'(tv[k].exp_n));
      for (int i = 0; i < tv[k].exp_n; i++)
        chk({tv[k].name, " word"}, (p0 + i < q.size()) ? q[p0+i] : 32'hxxxxxxxx, tv[k].data[95-32*i -: 32]);
      if (tv[k].exp_n == 0) chk({tv[k].name, " valid_never"}, 32'(valid_cnt - v0), 32'd0);
    end

    my_addr = 8'h5A;
    do_reset();
    w = 32'h0BADC0DE;
    pulse_start();
    send_addr(8'h5A);
    for (int i = 31; i >= 1; i--) send_bit(w[i]);
    bus.FRAME_END = 1'b1;
    send_bit(w[0]);
    bus.FRAME_END = 1'b0;
    chk("coincident valid_e1", 32'(bus.RX_VALID), 32'd0);
    chk("coincident done", 32'(bus.RX_DONE), 32'd1);
    chk("coincident ok", 32'(bus.RX_OK), 32'd1);
    tick();
    chk("latency valid_e2", 32'(bus.RX_VALID), 32'd1);
    chk("latency data", bus.RX_DATA, 32'h0BADC0DE);
    chk("done one_cycle", 32'(bus.RX_DONE), 32'd0);
    drain();

    do_reset();
    d0 = done_cnt; p0 = q.size();
    w = 32'h3;
    pulse_start();
    send_addr(8'h5A);
    send_word(32'h1);
    send_word(32'h2);
    for (int i = 31; i >= 1; i--) send_bit(w[i]);
    send_bit(w[0]);
    bus.RX_ACK = 1'b1;
    tick();
    idle(3);
    bus.RX_ACK = 1'b0;
    pulse_end();
    idle(2);
    chk("pushpop done", 32'(done_cnt - d0), 32'd1);
    chk("pushpop ok", 32'(last_ok), 32'd1);
    chk("pushpop count", 32'(q.size() - p0), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("pushpop word", (p0 + i < q.size()) ? q[p0+i] : 32'hxxxxxxxx, 32'(i + 1));

    do_reset();
    d0 = done_cnt; p0 = q.size();
    pulse_start();
    send_addr(8'h5A);
    send_word(32'h1);
    send_word(32'h2);
    send_word(32'h3);
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    pulse_start();
    send_addr(8'h5A);
    drain();
    send_word(32'h4);
    idle(2);
    pulse_end();
    idle(2);
    chk("restart done", 32'(done_cnt - d0), 32'd1);
    chk("restart ok", 32'(last_ok), 32'd1);
    drain();
    chk("restart count", 32'(q.size() - p0), 32'd3);
    chk("restart word0", (p0 < q.size()) ? q[p0] : 32'hxxxxxxxx, 32'h1);
    chk("restart word1", (p0 + 1 < q.size()) ? q[p0+1] : 32'hxxxxxxxx, 32'h2);
    chk("restart word2", (p0 + 2 < q.size()) ? q[p0+2] : 32'hxxxxxxxx, 32'h4);

    do_reset();
    pulse_start();
    send_addr(8'h5A);
    send_word(32'h77777777);
    idle(2);
    pulse_start();
    for (int i = 7; i >= 3; i--) send_bit(my_addr[i]);
    rst_n = 1'b0;
    #2;
    chk("midreset valid", 32'(bus.RX_VALID), 32'd0);
    chk("midreset data", bus.RX_DATA, 32'd0);
    chk("midreset rx_addr", 32'(bus.RX_ADDR), 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    d0 = done_cnt; p0 = q.size();
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    pulse_end();
    idle(2);
    chk("idle ignores end", 32'(done_cnt - d0), 32'd0);
    pulse_start();
    send_addr(8'h5A);
    send_word(32'hA5A5A5A5);
    idle(2);
    pulse_end();
    idle(2);
    chk("after_reset done", 32'(done_cnt - d0), 32'd1);
    chk("after_reset ok", 32'(last_ok), 32'd1);
    drain();
    chk("after_reset count", 32'(q.size() - p0), 32'd1);
    chk("after_reset word", (p0 < q.size()) ? q[p0] : 32'hxxxxxxxx, 32'hA5A5A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
